// File: rtl/proc_inst_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// proc_inst_sequencer_pkg
// Shared definitions for the instruction sequencer:
//   - sequencer state encoding (IDLE/ISSUE/WAIT/ERR)
//   - processor opcode constants (mv, mvt, add, sub)
//   - instruction field positions: III=[15:13], M=[12], rX=[11:9], D=[8:0]
//   - encode_inst(): packs the instruction fields into a 16-bit word
// -----------------------------------------------------------------------------
package proc_inst_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ERR   = 2'd3
    } seq_state_e;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVT = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    localparam int III_HI = 15;
    localparam int III_LO = 13;
    localparam int M_BIT  = 12;
    localparam int RX_HI  = 11;
    localparam int RX_LO  = 9;
    localparam int D_HI   = 8;
    localparam int D_LO   = 0;

    function automatic logic [15:0] encode_inst(input logic [2:0] op,
                                                input logic       m,
                                                input logic [2:0] rx,
                                                input logic [8:0] d);
        logic [15:0] w;
        w                = 16'h0000;
        w[III_HI:III_LO] = op;
        w[M_BIT]         = m;
        w[RX_HI:RX_LO]   = rx;
        w[D_HI:D_LO]     = d;
        return w;
    endfunction

endpackage

// File: rtl/proc_inst_sequencer_prog_ram.sv
// -----------------------------------------------------------------------------
// proc_inst_sequencer_prog_ram
// Program memory: 2**AW x 16 bits, synchronous write, asynchronous read.
// Contents are deliberately not reset so a loaded program survives Resetn.
// Ports:
//   Clock    in   system clock
//   wr_en    in   write strobe
//   wr_addr  in   AW  write address
//   wr_data  in   16  write data
//   rd_addr  in   AW  read address
//   rd_data  out  16  combinational read data
// -----------------------------------------------------------------------------
module proc_inst_sequencer_prog_ram #(
    parameter int AW = 5
) (
    input  logic          Clock,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [15:0]   wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [15:0]   rd_data
);

    logic [15:0] mem_r [0:(1<<AW)-1];

    // Synchronous write port
    always_ff @(posedge Clock) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/proc_inst_sequencer.sv
// -----------------------------------------------------------------------------
// proc_inst_sequencer
// Drives a processor's DIN/Run/Done issue interface from a loadable program
// memory. Each instruction is presented on DIN with a one-cycle Run pulse,
// then the sequencer waits for Done (bounded by TIMEOUT) before the next one.
// Ports:
//   Clock, Resetn          clock, synchronous active-low reset
//   Load/LoadAddr/LoadData program-memory write (IDLE only)
//   Start                  begin at PC=0 (IDLE) or clear error (ERR)
//   Count, Loop            program length / wrap mode, sampled on Start
//   Stop                   halt after the in-flight instruction completes
//   Done                   processor instruction-complete
//   DIN, Run               instruction word and issue strobe
//   Busy, Finished, Error  status (Finished is a one-cycle pulse)
//   PC, Issued             current index, completed-instruction count
// -----------------------------------------------------------------------------
module proc_inst_sequencer
    import proc_inst_sequencer_pkg::*;
#(
    parameter int AW      = 5,
    parameter int TIMEOUT = 15
) (
    input  logic          Clock,
    input  logic          Resetn,
    input  logic          Load,
    input  logic [AW-1:0] LoadAddr,
    input  logic [15:0]   LoadData,
    input  logic          Start,
    input  logic [AW:0]   Count,
    input  logic          Loop,
    input  logic          Stop,
    input  logic          Done,
    output logic [15:0]   DIN,
    output logic          Run,
    output logic          Busy,
    output logic          Finished,
    output logic          Error,
    output logic [AW-1:0] PC,
    output logic [15:0]   Issued
);

    localparam logic [AW:0] DEPTH     = {1'b1, {AW{1'b0}}};
    localparam logic [7:0]  TMO_LIMIT = 8'(TIMEOUT);

    seq_state_e    state_r;
    logic [AW:0]   count_r;
    logic          loop_r;
    logic          stop_r;
    logic [7:0]    tmo_r;
    logic [AW-1:0] pc_r;
    logic [15:0]   issued_r;
    logic [15:0]   din_r;
    logic          run_r;
    logic          busy_r;
    logic          fin_r;
    logic          err_r;

    logic          ram_we_s;
    logic [AW-1:0] rd_addr_s;
    logic [15:0]   rd_data_s;
    logic [15:0]   issue_word_s;
    logic [AW:0]   count_clamp_s;
    logic          last_s;
    logic [AW-1:0] pc_adv_s;
    logic [7:0]    tmo_next_s;
    logic [15:0]   issued_inc_s;

    proc_inst_sequencer_prog_ram #(.AW(AW)) u_prog_ram (
        .Clock   (Clock),
        .wr_en   (ram_we_s),
        .wr_addr (LoadAddr),
        .wr_data (LoadData),
        .rd_addr (rd_addr_s),
        .rd_data (rd_data_s)
    );

    // Next-PC, fetch address and saturating/limit arithmetic
    always_comb begin
        ram_we_s      = Load && (state_r == ST_IDLE);
        count_clamp_s = (Count > DEPTH) ? DEPTH : Count;
        last_s        = ({1'b0, pc_r} == (count_r - (AW+1)'(1'b1)));
        pc_adv_s      = (last_s && loop_r) ? {AW{1'b0}} : (pc_r + AW'(1'b1));
        // DIN is registered on the way into ISSUE, so fetch the word the
        // next ISSUE will present: index 0 from IDLE, the advanced PC from WAIT.
        rd_addr_s     = (state_r == ST_IDLE) ? {AW{1'b0}} : pc_adv_s;
        // A Load coinciding with Start must be visible in the first issue.
        issue_word_s  = (ram_we_s && (LoadAddr == rd_addr_s)) ? LoadData : rd_data_s;
        tmo_next_s    = tmo_r + 8'd1;
        issued_inc_s  = (issued_r == 16'hFFFF) ? 16'hFFFF : (issued_r + 16'd1);
    end

    // Sequencer FSM with registered interface outputs
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_r  <= ST_IDLE;
            count_r  <= {(AW+1){1'b0}};
            loop_r   <= 1'b0;
            stop_r   <= 1'b0;
            tmo_r    <= 8'd0;
            pc_r     <= {AW{1'b0}};
            issued_r <= 16'h0000;
            din_r    <= 16'h0000;
            run_r    <= 1'b0;
            busy_r   <= 1'b0;
            fin_r    <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            run_r <= 1'b0;
            din_r <= 16'h0000;
            fin_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    stop_r <= 1'b0;
                    if (Start) begin
                        count_r  <= count_clamp_s;
                        loop_r   <= Loop;
                        pc_r     <= {AW{1'b0}};
                        issued_r <= 16'h0000;
                        if (count_clamp_s == {(AW+1){1'b0}}) begin
                            fin_r <= 1'b1;
                        end else begin
                            state_r <= ST_ISSUE;
                            run_r   <= 1'b1;
                            din_r   <= issue_word_s;
                            busy_r  <= 1'b1;
                            tmo_r   <= 8'd0;
                        end
                    end
                end
                ST_ISSUE: begin
                    state_r <= ST_WAIT;
                    tmo_r   <= 8'd0;
                    stop_r  <= stop_r | Stop;
                end
                ST_WAIT: begin
                    stop_r <= stop_r | Stop;
                    tmo_r  <= tmo_next_s;
                    if (Done) begin
                        issued_r <= issued_inc_s;
                        if (stop_r || (last_s && !loop_r)) begin
                            state_r <= ST_IDLE;
                            fin_r   <= 1'b1;
                            busy_r  <= 1'b0;
                            stop_r  <= 1'b0;
                        end else begin
                            pc_r    <= pc_adv_s;
                            state_r <= ST_ISSUE;
                            run_r   <= 1'b1;
                            din_r   <= issue_word_s;
                        end
                    end else if (tmo_next_s == TMO_LIMIT) begin
                        state_r <= ST_ERR;
                        err_r   <= 1'b1;
                        busy_r  <= 1'b0;
                    end
                end
                ST_ERR: begin
                    if (Start) begin
                        state_r <= ST_IDLE;
                        err_r   <= 1'b0;
                        stop_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    err_r   <= 1'b0;
                end
            endcase
        end
    end

    assign DIN      = din_r;
    assign Run      = run_r;
    assign Busy     = busy_r;
    assign Finished = fin_r;
    assign Error    = err_r;
    assign PC       = pc_r;
    assign Issued   = issued_r;

endmodule

// File: tb/tb_proc_inst_sequencer.sv
// -----------------------------------------------------------------------------
// tb_proc_inst_sequencer
// Self-checking bench: a behavioural processor stub answers Run with Done
// after the opcode's latency (mv/mvt 2 cycles, add/sub 4 cycles). Expected
// Run cycles, DIN words, Finished cycle and Issued are derived from the
// program contents by summing latencies.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_proc_inst_sequencer;
    import proc_inst_sequencer_pkg::*;

    localparam int AW      = 5;
    localparam int DEPTH   = 32;
    localparam int TIMEOUT = 15;

    logic          Clock = 1'b0;
    logic          Resetn, Load, Start, Loop, Stop, Done;
    logic [AW-1:0] LoadAddr, PC;
    logic [15:0]   LoadData, DIN, Issued;
    logic [AW:0]   Count;
    logic          Run, Busy, Finished, Error;

    int n_vec = 0;
    int n_err = 0;

    always #5 Clock = ~Clock;

    proc_inst_sequencer #(.AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .Clock(Clock), .Resetn(Resetn), .Load(Load), .LoadAddr(LoadAddr),
        .LoadData(LoadData), .Start(Start), .Count(Count), .Loop(Loop),
        .Stop(Stop), .Done(Done), .DIN(DIN), .Run(Run), .Busy(Busy),
        .Finished(Finished), .Error(Error), .PC(PC), .Issued(Issued)
    );

    // ---------------- processor stub ----------------
    logic        done_en  = 1'b1;
    logic        p_active = 1'b0;
    int          p_step   = 0;
    logic [15:0] p_ir     = 16'h0000;
    logic [15:0] p_reg [0:7];

    function automatic int lat_of(input logic [15:0] w);
        return ((w[15:13] == OP_ADD) || (w[15:13] == OP_SUB)) ? 4 : 2;
    endfunction

    function automatic logic [15:0] result_of(input logic [15:0] w);
        logic [15:0] b;
        b = w[12] ? {7'b0, w[8:0]} : p_reg[w[2:0]];
        case (w[15:13])
            OP_MV:   return b;
            OP_MVT:  return {w[7:0], 8'h00};
            OP_ADD:  return p_reg[w[11:9]] + b;
            OP_SUB:  return p_reg[w[11:9]] - b;
            default: return p_reg[w[11:9]];
        endcase
    endfunction

    assign Done = done_en && p_active && (p_step == lat_of(p_ir) - 1);

    always @(posedge Clock) begin
        if (!Resetn) begin
            p_active <= 1'b0;
            p_step   <= 0;
            for (int i = 0; i < 8; i++) p_reg[i] <= 16'h0000;
        end else if (Run) begin
            p_active <= 1'b1;
            p_step   <= 1;
            p_ir     <= DIN;
        end else if (p_active) begin
            if (Done) begin
                p_reg[p_ir[11:9]] <= result_of(p_ir);
                p_active <= 1'b0;
            end else begin
                p_step <= p_step + 1;
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [15:0] mdl_mem [0:DEPTH-1];

    function automatic int exp_fin(input int cnt, input int nrun);
        int t = 1;
        for (int k = 0; k < nrun; k++) t += lat_of(mdl_mem[k % cnt]);
        return t;
    endfunction

    // ---------------- stimulus / monitor ----------------
    int          run_cyc[$];
    logic [15:0] run_word[$];
    int          fin_cyc, fin_n, err_cyc, busy_seen, din_leak;

    task automatic load_word(input int a, input logic [15:0] d);
        Load = 1'b1; LoadAddr = a[AW-1:0]; LoadData = d;
        @(negedge Clock);
        Load = 1'b0;
        mdl_mem[a] = d;
    endtask

    // Called at a negedge with the DUT idle; the half-cycle holding Start is cycle 0.
    task automatic exec(input int cnt, input bit lp, input int ncyc, input int stop_at, input int load_at);
        run_cyc.delete(); run_word.delete();
        fin_cyc = -1; fin_n = 0; err_cyc = -1; busy_seen = 0; din_leak = 0;
        Count = cnt[AW:0]; Loop = lp; Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0; Load = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            if (Run) begin
                run_cyc.push_back(c);
                run_word.push_back(DIN);
            end else if (DIN != 16'h0000) begin
                din_leak++;
            end
            if (Finished) begin
                fin_n++;
                if (fin_cyc < 0) fin_cyc = c;
            end
            if (Error && err_cyc < 0) err_cyc = c;
            if (Busy) busy_seen++;
            Stop = (c == stop_at);
            if (c == load_at) begin
                Load = 1'b1; LoadAddr = '0; LoadData = 16'hFFFF;
            end else begin
                Load = 1'b0;
            end
            @(negedge Clock);
        end
        Stop = 1'b0; Load = 1'b0;
    endtask

    task automatic compare_run(input string tag, input int cnt, input int nrun);
        int t = 1;
        check_eq({tag, "_nrun"}, run_cyc.size(), nrun);
        for (int k = 0; k < nrun; k++) begin
            if (k < run_cyc.size()) begin
                check_eq($sformatf("%s_runcyc%0d", tag, k), run_cyc[k], t);
                check_eq($sformatf("%s_din%0d", tag, k), run_word[k], mdl_mem[k % cnt]);
            end
            t += lat_of(mdl_mem[k % cnt]);
        end
        check_eq({tag, "_fincyc"}, fin_cyc, t);
        check_eq({tag, "_finpulses"}, fin_n, 1);
        check_eq({tag, "_issued"}, Issued, nrun);
        check_eq({tag, "_dinleak"}, din_leak, 0);
    endtask

    function automatic logic [15:0] rand_inst();
        return encode_inst(3'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                           3'($urandom_range(0, 7)), 9'($urandom_range(0, 511)));
    endfunction

    initial begin
        int k, tk, stop_at, fin, cnt, nrun;
        Resetn = 1'b0; Load = 1'b0; Start = 1'b0; Loop = 1'b0; Stop = 1'b0;
        LoadAddr = '0; LoadData = 16'h0000; Count = '0;
        repeat (3) @(negedge Clock);

        // Reset state
        check_eq("rst_run", Run, 0);
        check_eq("rst_din", DIN, 0);
        check_eq("rst_busy", Busy, 0);
        check_eq("rst_fin", Finished, 0);
        check_eq("rst_err", Error, 0);
        check_eq("rst_pc", PC, 0);
        check_eq("rst_issued", Issued, 0);
        Resetn = 1'b1;
        @(negedge Clock);

        // 1: mv r0,#5 ; add r0,#3
        load_word(0, 16'h1005);
        load_word(1, 16'h5003);
        exec(2, 1'b0, 12, 0, 0);
        compare_run("t1", 2, 2);
        check_eq("t1_r0", p_reg[0], 16'h0008);

        // 2: mvt r1,#0xAB loaded in the same cycle as Start
        Load = 1'b1; LoadAddr = '0; LoadData = 16'h32AB; mdl_mem[0] = 16'h32AB;
        exec(1, 1'b0, 6, 0, 0);
        compare_run("t2", 1, 1);
        check_eq("t2_r1", p_reg[1], 16'hAB00);

        // 3: looping program halted by Stop in the WAIT of a sub
        load_word(0, 16'h1005);
        load_word(1, 16'h7001);
        k = 2 * $urandom_range(0, 2) + 1;
        tk = exp_fin(2, k);
        stop_at = tk + 1;
        fin = tk + lat_of(mdl_mem[1]);
        exec(2, 1'b1, fin + 6, stop_at, 0);
        compare_run("t3", 2, k + 1);
        check_eq("t3_pc", PC, 1);
        check_eq("t3_busy", Busy, 0);

        // 4: Done never arrives -> ERR after TIMEOUT wait cycles
        done_en = 1'b0;
        exec(1, 1'b0, TIMEOUT + 6, 0, 0);
        check_eq("t4_nrun", run_cyc.size(), 1);
        check_eq("t4_errcyc", err_cyc, 1 + TIMEOUT + 1);
        check_eq("t4_nofin", fin_n, 0);
        check_eq("t4_busy", Busy, 0);
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        check_eq("t4_errclr", Error, 0);
        check_eq("t4_busy2", Busy, 0);
        done_en = 1'b1;
        Resetn = 1'b0;
        @(negedge Clock);
        Resetn = 1'b1;
        @(negedge Clock);

        // 5: Count=0, then Load while busy must not alter memory
        exec(0, 1'b0, 5, 0, 0);
        compare_run("t5a", 0, 0);
        check_eq("t5a_busy", busy_seen, 0);
        exec(2, 1'b0, 12, 0, 2);
        compare_run("t5b", 2, 2);
        exec(2, 1'b0, 12, 0, 0);
        compare_run("t5c", 2, 2);

        // 6: reset during the WAIT of an add
        load_word(1, 16'h5003);
        Count = 2; Loop = 1'b0; Start = 1'b1;
        @(negedge Clock);                  // cycle 1: mv issued
        Start = 1'b0;
        repeat (3) @(negedge Clock);       // cycle 4: WAIT of add
        check_eq("t6_pre_issued", Issued, 1);
        Resetn = 1'b0;
        @(negedge Clock);
        Resetn = 1'b1;
        check_eq("t6_run", Run, 0);
        check_eq("t6_busy", Busy, 0);
        check_eq("t6_issued", Issued, 0);
        check_eq("t6_pc", PC, 0);
        exec(2, 1'b0, 12, 0, 0);
        compare_run("t6_rerun", 2, 2);

        // Random programs
        for (int it = 0; it < 12; it++) begin
            cnt = $urandom_range(1, 8);
            for (int a = 0; a < cnt; a++) load_word(a, rand_inst());
            exec(cnt, 1'b0, exp_fin(cnt, cnt) + 4, 0, 0);
            compare_run($sformatf("rnd%0d", it), cnt, cnt);
        end

        // Count above memory depth is clamped
        for (int a = 0; a < DEPTH; a++) load_word(a, rand_inst());
        cnt = 40;
        nrun = DEPTH;
        exec(cnt, 1'b0, exp_fin(cnt, nrun) + 4, 0, 0);
        compare_run("clamp", cnt, nrun);
        check_eq("clamp_pc", PC, DEPTH - 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
